booth_mul_sched: RTL and testbench
==================================

// Module: booth_mul_sched
// PURPOSE
//  Shares one iterative radix-2 Booth signed multiplier between NREQ requesters.
//  Round-robin arbitration; valid/ready handshake on each request port; one shared response port.
//  Runs one Booth step per clock, so a multiply occupies the datapath for WIDTH cycles.
//  Sits between the arithmetic clients and the single shared multiply resource.
// PARAMETERS
//  WIDTH  16  operand width; signed two's complement
//  NREQ   4   number of requesters, >=2
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           asynchronous, active-high reset
//  req_valid  in   NREQ        request i holds valid operands
//  req_a      in   NREQ*WIDTH  multiplicand, slice i = [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  multiplier, same slicing
//  req_ready  out  NREQ        one-hot accept; transfer when valid & ready
//  rsp_valid  out  1           result available
//  rsp_id     out  clog2(NREQ) index of the requester that owns the result
//  rsp_prod   out  2*WIDTH     signed product
//  rsp_ready  in   1           consumer accepts result
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; rsp_valid=0, rsp_id=0, rsp_prod=0; last_grant=NREQ-1.
//    An in-flight operation is discarded. No response is ever produced for it.
//  - req_ready is combinational: it is nonzero only in IDLE with rst low.
//    It is the one-hot of the first valid index, searching from last_grant+1 with wrap.
//  - FSM IDLE -> RUN -> DONE -> IDLE:
//    IDLE: on any req_valid, grant g. Latch a,b,id=g. Load acc=0, mq=b, q=0, cnt=0. Set last_grant=g. Go to RUN.
//    RUN: one Booth step per cycle.
//      {mq[0],q}: 10 -> acc-=a; 01 -> acc+=a; 00/11 -> no add.
//      Then arithmetic right shift of {acc,mq,q} by 1. cnt++.
//      At cnt==WIDTH-1, take the last step and go to DONE.
//    DONE: rsp_valid=1; rsp_prod={acc,mq} low 2*WIDTH bits; rsp_id=id.
//      All three are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
//      No new accept occurs in the handshake cycle.
//  - Latency: accept at edge T -> rsp_valid high from edge T+WIDTH.
//    Back-to-back spacing is WIDTH+2 cycles with rsp_ready tied high.
//  - Arithmetic: acc is WIDTH+1 bits, sign-extended, so -a never overflows.
//    The product is exact for all operand pairs, including (-2^(W-1))^2 = +2^(2W-2).
//  - A requester may drop req_valid before it is granted; no state is kept for it.
//    Operands are sampled only in the accept cycle.
//  - rsp_ready held high outside DONE is ignored.
// STRUCTURE
//  - Package booth_pkg holds: state enum {IDLE,RUN,DONE}; localparams WIDTH_DEF=16, NREQ_DEF=4;
//    CNT_W=$clog2(WIDTH); ID_W=$clog2(NREQ).
//  - Sub-module booth_step_core holds the datapath only: acc/mq/q/a registers and the step adder.
//    Its inputs are load, step, a, b. Its output is prod.
//  - The top level holds the round-robin arbiter, the FSM, the counter and the response registers.
// TESTING
//  1. req0 a=3, b=-4, rsp_ready=1 -> rsp_prod=-12, rsp_id=0, rsp_valid exactly WIDTH cycles after accept.
//  2. a=-32768, b=-32768 -> 0x40000000. a=0x7FFF, b=0x7FFF -> 0x3FFF0001. a=7, b=0 -> 0.
//  3. All four req_valid held high with distinct operands -> grant order 0,1,2,3,0.
//     Each rsp_id matches the product of its own operands.
//  4. rsp_ready low for 5 cycles in DONE -> rsp_prod/rsp_id stable, req_ready=0 throughout.
//     Accept resumes one cycle after the handshake.
//  5. rst pulsed at RUN step 7 (asynchronously, mid-cycle) -> outputs 0 immediately.
//     No response appears for the in-flight operation; the next grant goes to req0.
//  6. req2 valid 1 cycle then dropped while req0 busy; only req3 valid afterwards -> req3 granted, req2 never answered.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier scheduler.
package booth_pkg;

  // Scheduler states: waiting for a request, stepping, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // What a single radix-2 Booth step does to the accumulator.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } booth_op_t;

  localparam int WIDTH_DEF = 16;
  localparam int NREQ_DEF  = 4;
  localparam int CNT_W     = $clog2(WIDTH_DEF);
  localparam int ID_W      = $clog2(NREQ_DEF);

  // Decode the Booth pair {current multiplier LSB, previously shifted-out bit}.
  function automatic booth_op_t booth_decode(input logic lsb, input logic prev);
    booth_op_t op;
    case ({lsb, prev})
      2'b10:   op = OP_SUB;
      2'b01:   op = OP_ADD;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_step_core.sv
// Booth datapath: operand register, accumulator, multiplier/product shift
// register and the single add/subtract used by each step.
module booth_step_core
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod
);

  // acc carries one guard bit so subtracting the most negative multiplicand
  // cannot overflow before the arithmetic shift.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             q_bit;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   sum;

  // Step adder: add, subtract or pass the accumulator per the Booth pair.
  always_comb begin
    a_ext = {a_reg[WIDTH-1], a_reg};
    sum   = acc;
    case (booth_decode(mq[0], q_bit))
      OP_ADD:  sum = acc + a_ext;
      OP_SUB:  sum = acc - a_ext;
      default: sum = acc;
    endcase
  end

  // Load fresh operands, or apply one step followed by the arithmetic right shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      acc   <= '0;
      mq    <= '0;
      q_bit <= 1'b0;
    end else if (load) begin
      a_reg <= a;
      acc   <= '0;
      mq    <= b;
      q_bit <= 1'b0;
    end else if (step) begin
      acc   <= {sum[WIDTH], sum[WIDTH:1]};
      mq    <= {sum[0], mq[WIDTH-1:1]};
      q_bit <= mq[0];
    end
  end

  // The exact product always fits in the low 2*WIDTH bits of {acc, mq}.
  assign prod = {acc[WIDTH-1:0], mq};

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one iterative Booth multiplier among NREQ
// requesters, with a single valid/ready response port.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_prod,
  input  logic                      rsp_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(NREQ);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    grant_id;
  logic [NREQ-1:0]  grant_oh;
  logic             grant_any;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    id_q;
  logic             load;
  logic             step;
  logic             last_step;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [2*WIDTH-1:0] core_prod;

  // Round-robin search for the first valid requester after the last grant.
  always_comb begin
    grant_oh  = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any     = 1'b1;
        grant_id      = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  assign a_sel     = req_a[grant_id*WIDTH +: WIDTH];
  assign b_sel     = req_b[grant_id*WIDTH +: WIDTH];
  assign last_step = (cnt == CW'(WIDTH - 1));

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept, step WIDTH times, hold the result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: grants only while idle, response fields only while done.
  always_comb begin
    req_ready = '0;
    load      = 1'b0;
    step      = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_prod  = '0;
    case (state)
      IDLE: begin
        if (!rst) req_ready = grant_oh;
        load = grant_any;
      end
      RUN: step = 1'b1;
      DONE: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_prod  = core_prod;
      end
      default: ;
    endcase
  end

  // Step counter, owner id of the running operation and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      id_q       <= '0;
      last_grant <= IW'(NREQ - 1);
    end else if (load) begin
      cnt        <= '0;
      id_q       <= grant_id;
      last_grant <= grant_id;
    end else if (step) begin
      cnt        <= cnt + CW'(1);
    end
  end

  booth_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (a_sel),
    .b    (b_sel),
    .prod (core_prod)
  );

endmodule

// File: tb/tb_booth_mul_sched.sv
// Scoreboard bench for booth_mul_sched: accepted requests push their
// hand-computed product, a response monitor pops and compares.
module tb_booth_mul_sched;

  localparam int W = 16;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*W-1:0]   rsp_prod;
  logic             rsp_ready;

  typedef struct {
    int             id;
    logic [2*W-1:0] prod;
    int             acc_cyc;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] exp_arr [N];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             rise_cyc = 0;
  logic           prev_valid = 1'b0;

  booth_mul_sched #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready)
  );

  // 10 ns clock and an edge counter used for latency/spacing checks.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present operands on requester idx along with the product they should give.
  task automatic applyStimulus(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] e);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    exp_arr[idx]      = e;
    req_valid[idx]    = 1'b1;
  endtask

  // Wait (bounded) for an accept and check it went to requester idx.
  task automatic waitGrant(input int idx, output int gcyc);
    bit seen = 1'b0;
    logic [63:0] want;
    want = 64'd1 << idx;
    gcyc = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL grant_timeout actual=none required=req%0d", idx);
    end else begin
      checkOutput("grant", 64'(req_ready), want);
      gcyc = cyc + 1;
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) until every accepted request has been answered.
  task automatic waitDrain();
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Accept monitor: every transfer pushes its expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id      = i;
          e.prod    = exp_arr[i];
          e.acc_cyc = cyc + 1;
          sb.push_back(e);
        end
      end
    end
  end

  // Response monitor: pops on each handshake and checks owner, product, latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_rsp actual=id%0d required=none", rsp_id);
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
          checkOutput("rsp_prod", 64'(rsp_prod), 64'(e.prod));
          checkOutput("latency", 64'(rise_cyc - e.acc_cyc), 64'(W));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    bad++;
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int g;
    int prev_g;
    int ord [5];
    int seen_valid;
    ord = '{0, 1, 2, 3, 0};
    prev_g = 0;

    // Reset state, with requests pending to show req_ready is suppressed.
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) exp_arr[i] = '0;
    #12;
    checkOutput("rst_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_id", 64'(rsp_id), 64'd0);
    checkOutput("rst_prod", 64'(rsp_prod), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Simple signed product on requester 0.
    $display("[TB] basic 3 * -4");
    applyStimulus(0, 16'd3, 16'hFFFC, 32'hFFFF_FFF4);
    waitGrant(0, g);
    req_valid[0] = 1'b0;
    waitDrain();

    // Extremes and zero.
    $display("[TB] corner operands");
    applyStimulus(0, 16'h8000, 16'h8000, 32'h4000_0000);
    waitGrant(0, g);
    applyStimulus(0, 16'h7FFF, 16'h7FFF, 32'h3FFF_0001);
    waitGrant(0, g);
    applyStimulus(0, 16'd7, 16'd0, 32'h0000_0000);
    waitGrant(0, g);
    req_valid[0] = 1'b0;
    waitDrain();

    // A requester that withdraws before being granted is never served.
    $display("[TB] dropped request");
    applyStimulus(0, 16'd100, 16'hFFFD, 32'hFFFF_FED4);
    waitGrant(0, g);
    req_valid[0] = 1'b0;
    applyStimulus(2, 16'd55, 16'd55, 32'h0000_0000);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    applyStimulus(3, 16'hFFFB, 16'd6, 32'hFFFF_FFE2);
    waitGrant(3, g);
    req_valid[3] = 1'b0;
    waitDrain();

    // Consumer stalls: result held, no accepts, resume one cycle after handshake.
    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1, 16'd1234, 16'd56, 32'h0001_0DF0);
    waitGrant(1, g);
    req_valid[1] = 1'b0;
    applyStimulus(2, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    seen_valid = 0;
    for (int k = 0; k < 100 && seen_valid == 0; k++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1;
    end
    checkOutput("stall_reached", 64'(seen_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_valid", 64'(rsp_valid), 64'd1);
      checkOutput("stall_id", 64'(rsp_id), 64'd1);
      checkOutput("stall_prod", 64'(rsp_prod), 64'h0001_0DF0);
      checkOutput("stall_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("handshake_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    checkOutput("resume", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    waitDrain();

    // Asynchronous reset in the middle of a multiply discards it.
    $display("[TB] reset mid-operation");
    applyStimulus(1, 16'd9, 16'd9, 32'h0000_0051);
    waitGrant(1, g);
    req_valid[1] = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 64'(rsp_valid), 64'd0);
    checkOutput("mid_rst_id", 64'(rsp_id), 64'd0);
    checkOutput("mid_rst_prod", 64'(rsp_prod), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1;
    end
    checkOutput("no_rsp_after_rst", 64'(seen_valid), 64'd0);
    @(posedge clk);
    #1;

    // All requesters busy: fair rotation starting from requester 0.
    $display("[TB] round robin");
    applyStimulus(0, 16'd2, 16'd3, 32'h0000_0006);
    applyStimulus(1, 16'hFFF9, 16'd11, 32'hFFFF_FFB3);
    applyStimulus(2, 16'd300, 16'hFF38, 32'hFFFF_15A0);
    applyStimulus(3, 16'h8000, 16'd1, 32'hFFFF_8000);
    for (int j = 0; j < 5; j++) begin
      waitGrant(ord[j], g);
      if (j > 0) checkOutput("spacing", 64'(g - prev_g), 64'(W + 2));
      prev_g = g;
      if (j == 0) applyStimulus(0, 16'hFC18, 16'hFC18, 32'h000F_4240);
      else        req_valid[ord[j]] = 1'b0;
    end
    waitDrain();

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
